// File: rtl/ws2812_multi_driver.sv
// Parallel WS2812B serializer: N_STRINGS lanes shift pixels in lockstep from a one-entry
// holding register, with cycle-programmable bit timing, a latch gap and underflow flagging.

module ws2812_lane #(
  parameter int BITS_PER_LED = 24,
  parameter int CW           = 7,
  parameter int T0H_CYC      = 40,
  parameter int T1H_CYC      = 80
) (
  input  logic                    clk_100,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    shift,
  input  logic                    en,
  input  logic [CW-1:0]           cyc,
  input  logic [BITS_PER_LED-1:0] pix,
  output logic                    sdi
);
  localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H = CW'(T1H_CYC);

  logic [BITS_PER_LED-1:0] sr;

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      sr  <= '0;
      sdi <= 1'b0;
    end else begin
      if (load)       sr <= pix;
      else if (shift) sr <= sr << 1;
      sdi <= en && (cyc < (sr[BITS_PER_LED-1] ? T1H : T0H));
    end
  end
endmodule

module ws2812_multi_driver #(
  parameter int N_STRINGS         = 2,
  parameter int N_LEDS_PER_STRING = 8,
  parameter int BITS_PER_LED      = 24,
  parameter int TBIT_CYC          = 125,
  parameter int T0H_CYC           = 40,
  parameter int T1H_CYC           = 80,
  parameter int RESET_CYC         = 6000
) (
  input  logic                              clk_100,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [N_STRINGS*BITS_PER_LED-1:0] s_data,
  input  logic                              underflow_clr,
  output logic [N_STRINGS-1:0]              led_sdi,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              underflow
);
  localparam int CMAX = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = ($clog2(BITS_PER_LED) > 0) ? $clog2(BITS_PER_LED) : 1;
  localparam int PW   = ($clog2(N_LEDS_PER_STRING) > 0) ? $clog2(N_LEDS_PER_STRING) : 1;
  localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] RST_M1  = CW'(RESET_CYC - 1);
  localparam logic [BW-1:0] BIT_M1  = BW'(BITS_PER_LED - 1);
  localparam logic [PW-1:0] PIX_M1  = PW'(N_LEDS_PER_STRING - 1);

  generate
    if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && RESET_CYC >= 2 && N_STRINGS >= 1))
      begin : g_bad_params
        $error("ws2812_multi_driver: illegal timing/string parameters");
      end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t  state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [BW-1:0] bitc, bit_nxt;
  logic [PW-1:0] pix, pix_nxt;
  logic [N_STRINGS-1:0][BITS_PER_LED-1:0] hold_data;
  logic hold_valid, hold_valid_nxt, accept;
  logic load, shift, uf_evt, fd_nxt;

  assign accept = s_valid & s_ready;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    bit_nxt   = bitc;
    pix_nxt   = pix;
    load      = 1'b0;
    shift     = 1'b0;
    uf_evt    = 1'b0;
    fd_nxt    = 1'b0;
    case (state)
      IDLE: if (hold_valid) begin
        state_nxt = SHIFT;
        load      = 1'b1;
        cyc_nxt   = '0;
        bit_nxt   = '0;
        pix_nxt   = '0;
      end
      SHIFT: if (cyc == TBIT_M1) begin
        cyc_nxt = '0;
        if (bitc == BIT_M1) begin
          bit_nxt = '0;
          if (pix != PIX_M1 && hold_valid) begin
            load    = 1'b1;
            pix_nxt = pix + 1'b1;
          end else begin
            // starved before the last pixel: abandon the frame and latch what was sent
            uf_evt    = (pix != PIX_M1);
            state_nxt = LATCH;
          end
        end else begin
          bit_nxt = bitc + 1'b1;
          shift   = 1'b1;
        end
      end else begin
        cyc_nxt = cyc + 1'b1;
      end
      LATCH: if (cyc == RST_M1) begin
        fd_nxt    = 1'b1;
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end else begin
        cyc_nxt = cyc + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // load and accept are exclusive: one needs hold full, the other hold empty
  always_comb begin
    hold_valid_nxt = hold_valid;
    if (load)        hold_valid_nxt = 1'b0;
    else if (accept) hold_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      bitc       <= '0;
      pix        <= '0;
      hold_valid <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      bitc       <= bit_nxt;
      pix        <= pix_nxt;
      hold_valid <= hold_valid_nxt;
      s_ready    <= ~hold_valid_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= fd_nxt;
      if (uf_evt)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (accept) hold_data <= s_data;
  end

  generate
    for (genvar k = 0; k < N_STRINGS; k++) begin : g_lane
      ws2812_lane #(
        .BITS_PER_LED(BITS_PER_LED), .CW(CW), .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC)
      ) u_lane (
        .clk_100(clk_100), .rst_n(rst_n), .load(load), .shift(shift),
        .en(state == SHIFT), .cyc(cyc), .pix(hold_data[k]), .sdi(led_sdi[k])
      );
    end
  endgenerate
endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Bench for ws2812_multi_driver: decodes each led_sdi waveform back into pixels and
// compares against the beats sent, plus frame/latch/underflow/reset sequences.

module tb_ws2812_multi_driver;
  localparam int NS = 4, B = 32, NL = 4, TB = 10, T0 = 3, T1 = 7, RC = 20;
  localparam int DW = NS * B;

  logic clk_100 = 1'b0, rst_n = 1'b0, s_valid = 1'b0, underflow_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, busy, frame_done, underflow;
  logic [NS-1:0] led_sdi;

  ws2812_multi_driver #(
    .N_STRINGS(NS), .N_LEDS_PER_STRING(NL), .BITS_PER_LED(B), .TBIT_CYC(TB),
    .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(RC)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .underflow_clr(underflow_clr), .led_sdi(led_sdi), .busy(busy),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic [DW-1:0] pix [NL];
    int            nsup;
    bit            exp_uf;
  } vec_t;

  int checks = 0, failures = 0;
  int tcyc = 0;
  int rises [NS][$];
  int his   [NS][$];
  int fd_q  [$];
  int hic   [NS];
  logic [NS-1:0] prev = '0;
  bit uf_seen = 0;
  int rdy_low = 0;

  // waveform monitor: rising-edge times and high widths per string
  initial forever begin
    @(posedge clk_100); #1;
    tcyc++;
    for (int k = 0; k < NS; k++) begin
      if (led_sdi[k] && !prev[k]) rises[k].push_back(tcyc);
      if (led_sdi[k]) hic[k]++;
      if (!led_sdi[k] && prev[k]) begin his[k].push_back(hic[k]); hic[k] = 0; end
    end
    prev = led_sdi;
    if (frame_done) fd_q.push_back(tcyc);
    if (underflow) uf_seen = 1;
    if (s_valid && !s_ready) rdy_low++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < NS; k++) begin rises[k].delete(); his[k].delete(); hic[k] = 0; end
    fd_q.delete();
    uf_seen = 0;
    rdy_low = 0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && t < 5000) begin @(negedge clk_100); t++; end
    if (t >= 5000) chk("send_timeout", 0, 1);
    @(negedge clk_100);
    s_valid = 1'b0;
  endtask

  task automatic wait_fd(input int n, input int budget);
    int t = 0;
    while (fd_q.size() < n && t < budget) begin @(negedge clk_100); t++; end
    if (t >= budget) chk("frame_done_timeout", fd_q.size(), n);
    repeat (4) @(negedge clk_100);
  endtask

  // pq holds the pixels expected on the wire, in order, over exp_fd frames
  task automatic check_frame(input string tag, input logic [DW-1:0] pq[$],
                             input bit exp_uf, input int exp_fd);
    int nb = 0, bad_bit = 0, bad_per = 0, ngap = 0, expn, last, dly;
    expn = pq.size() * B;
    for (int k = 0; k < NS; k++) begin
      nb += his[k].size();
      for (int i = 0; i < his[k].size() && i < expn; i++) begin
        logic eb;
        eb = pq[i / B][k*B + B-1 - (i % B)];
        if (!((his[k][i] == T1 && eb) || (his[k][i] == T0 && !eb))) bad_bit++;
      end
      for (int i = 1; i < rises[k].size(); i++) begin
        int d;
        d = rises[k][i] - rises[k][i-1];
        if (d == TB + RC + 1) ngap++;
        else if (d != TB) bad_per++;
      end
    end
    chk({tag, "_nbits"}, nb, NS * expn);
    chk({tag, "_bitval"}, bad_bit, 0);
    chk({tag, "_period"}, bad_per, 0);
    chk({tag, "_gaps"}, ngap, NS * (exp_fd - 1));
    chk({tag, "_underflow"}, underflow, exp_uf);
    chk({tag, "_fdone_cnt"}, fd_q.size(), exp_fd);
    // frame_done lands about RESET_CYC after the final bit period ends
    if (rises[0].size() > 0 && fd_q.size() > 0) begin
      last = rises[0][rises[0].size()-1] + TB;
      dly  = fd_q[fd_q.size()-1] - last;
      chk({tag, "_fdone_pos"}, (dly >= RC - 2 && dly <= RC + 1), 1);
    end
    chk({tag, "_idle_low"}, {busy, led_sdi}, 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit rnd_gap);
    logic [DW-1:0] pq[$];
    clear_mon();
    for (int p = 0; p < v.nsup; p++) begin
      send(v.pix[p]);
      pq.push_back(v.pix[p]);
      if (rnd_gap) repeat ($urandom_range(0, 40)) @(negedge clk_100);
    end
    wait_fd(1, 3000);
    check_frame(tag, pq, v.exp_uf, 1);
    if (v.exp_uf) begin
      underflow_clr = 1'b1;
      @(negedge clk_100);
      underflow_clr = 1'b0;
      chk({tag, "_uf_clr"}, underflow, 0);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pix();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] dec_word(input int k, input int p);
    logic [31:0] w = '0;
    for (int i = 0; i < B; i++)
      if (p*B + i < his[k].size()) w[B-1-i] = (his[k][p*B + i] == T1);
    return w;
  endfunction

  vec_t tbl [7];
  vec_t v;

  initial begin
    tbl[0].nsup = NL; tbl[0].exp_uf = 0;
    tbl[1].nsup = NL; tbl[1].exp_uf = 0;
    tbl[2].nsup = NL; tbl[2].exp_uf = 0;
    tbl[3].nsup = NL; tbl[3].exp_uf = 0;
    tbl[4].nsup = NL; tbl[4].exp_uf = 0;
    tbl[5].nsup = 3;  tbl[5].exp_uf = 1;
    tbl[6].nsup = 1;  tbl[6].exp_uf = 1;
    for (int p = 0; p < NL; p++) begin
      tbl[0].pix[p] = 128'hFF000000_00FF0000_0000FF00_000000FF;
      tbl[1].pix[p] = '0;
      tbl[2].pix[p] = '1;
      tbl[3].pix[p] = {4{32'hAAAA_5555}};
      tbl[4].pix[p] = rnd_pix();
      tbl[5].pix[p] = rnd_pix();
      tbl[6].pix[p] = rnd_pix();
    end

    repeat (3) @(negedge clk_100);
    chk("rst_led", led_sdi, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_uf", underflow, 0);
    rst_n = 1'b1;
    @(negedge clk_100);
    chk("ready_after_rst", s_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
      if (i == 0) begin
        chk("s0_pix0", dec_word(0, 0), 32'h000000FF);
        chk("s3_pix0", dec_word(3, 0), 32'hFF000000);
      end
    end

    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NL; p++) v.pix[p] = rnd_pix();
      v.nsup   = $urandom_range(1, NL);
      v.exp_uf = (v.nsup < NL);
      run_vec($sformatf("rnd%0d", r), v, 1'b1);
    end

    // underflow with clear held high across the event: set must still win
    clear_mon();
    underflow_clr = 1'b1;
    send(rnd_pix());
    send(rnd_pix());
    wait_fd(1, 3000);
    chk("uf_set_wins", uf_seen, 1);
    chk("uf_cleared_after", underflow, 0);
    underflow_clr = 1'b0;

    // three frames with s_valid held high throughout
    begin
      logic [DW-1:0] pq[$];
      clear_mon();
      for (int p = 0; p < 3 * NL; p++) begin
        pq.push_back(rnd_pix());
        send(pq[p]);
      end
      wait_fd(3, 6000);
      check_frame("cont", pq, 1'b0, 3);
      chk("cont_ready_drop", rdy_low > 0, 1);
    end

    // reset in the middle of pixel 1, then a clean frame
    send(rnd_pix());
    send(rnd_pix());
    repeat (B * TB + 40) @(negedge clk_100);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk_100);
    chk("mid_rst_led", led_sdi, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk_100);
    chk("mid_rst_ready", s_ready, 1);
    for (int p = 0; p < NL; p++) v.pix[p] = rnd_pix();
    v.nsup = NL;
    v.exp_uf = 0;
    run_vec("post_rst", v, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
